ex_mem_stage_skid: RTL and testbench

- Parametrised EX→MEM pipeline stage for the dual-issue core; generalises the per-lane EX/MEM registers into one LANES-wide stage.
- Carries a valid/ready handshake on both sides, with a 2-entry (main + skid) buffer so backpressure never drops a bundle.
- Supports per-lane kill, optional killing of younger lanes, a global flush, and a saturating stall counter.
- Lane 0 is the oldest instruction in the bundle.

---
 rtl/ex_mem_stage_skid_if.sv | 33 +++
 rtl/ex_mem_stage_skid.sv | 115 +++++++++++
 tb/tb_ex_mem_stage_skid.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/ex_mem_stage_skid_if.sv
// Handshake and data bundle between the EX stage, the EX/MEM skid stage and MEM.
// slave is the stage's view; master is the view of whoever drives EX and consumes MEM.
interface ex_mem_stage_skid_if #(
    parameter int unsigned LANES       = 2,
    parameter int unsigned PAYLOAD_W   = 85,
    parameter int unsigned CTRL_W      = 5,
    parameter int unsigned STALL_CNT_W = 16
);
    logic                         in_valid;
    logic                         in_ready;
    logic [LANES-1:0]             in_lane_valid;
    logic [LANES*PAYLOAD_W-1:0]   in_payload;
    logic [LANES*CTRL_W-1:0]      in_ctrl;
    logic [LANES-1:0]             flush_lane;
    logic                         flush_all;
    logic                         out_valid;
    logic                         out_ready;
    logic [LANES-1:0]             out_lane_valid;
    logic [LANES*PAYLOAD_W-1:0]   out_payload;
    logic [LANES*CTRL_W-1:0]      out_ctrl;
    logic [1:0]                   occupancy;
    logic [STALL_CNT_W-1:0]       stall_cnt;

    modport slave (
        input  in_valid, in_lane_valid, in_payload, in_ctrl, flush_lane, flush_all, out_ready,
        output in_ready, out_valid, out_lane_valid, out_payload, out_ctrl, occupancy, stall_cnt
    );

    modport master (
        output in_valid, in_lane_valid, in_payload, in_ctrl, flush_lane, flush_all, out_ready,
        input  in_ready, out_valid, out_lane_valid, out_payload, out_ctrl, occupancy, stall_cnt
    );
endinterface

// File: rtl/ex_mem_stage_skid.sv
// LANES-wide EX->MEM pipeline register with a main/skid entry pair, per-lane kill,
// global flush and a saturating backpressure counter. Lane 0 is the oldest.
module ex_mem_stage_skid #(
    parameter int unsigned LANES        = 2,
    parameter int unsigned PAYLOAD_W    = 85,
    parameter int unsigned CTRL_W       = 5,
    parameter int unsigned KILL_YOUNGER = 1,
    parameter int unsigned STALL_CNT_W  = 16
) (
    input logic               clk,
    input logic               reset,
    ex_mem_stage_skid_if.slave bus
);
    localparam int unsigned PW = LANES * PAYLOAD_W;
    localparam int unsigned CW = LANES * CTRL_W;

    typedef struct packed {
        logic             vld;
        logic [LANES-1:0] lv;
        logic [PW-1:0]    pl;
        logic [CW-1:0]    ct;
    } entry_t;

    entry_t                 m_q, m_d;
    entry_t                 s_q, s_d;
    entry_t                 in_e;
    logic                   in_ready_q;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;
    logic [LANES-1:0]       kill;
    logic                   accept, emit, store;

    // A flush on an older lane optionally takes every younger lane with it.
    always_comb begin
        logic older_flushed;
        kill          = '0;
        older_flushed = 1'b0;
        for (int unsigned i = 0; i < LANES; i++) begin
            kill[i]       = bus.flush_lane[i] | ((KILL_YOUNGER != 0) & older_flushed);
            older_flushed = older_flushed | bus.flush_lane[i];
        end
    end

    always_comb begin
        in_e = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            in_e.lv[i] = bus.in_lane_valid[i] & ~kill[i];
            if (!kill[i]) begin
                in_e.pl[i*PAYLOAD_W +: PAYLOAD_W] = bus.in_payload[i*PAYLOAD_W +: PAYLOAD_W];
            end
            if (in_e.lv[i]) begin
                in_e.ct[i*CTRL_W +: CTRL_W] = bus.in_ctrl[i*CTRL_W +: CTRL_W];
            end
        end
        in_e.vld = |in_e.lv;
    end

    assign accept = bus.in_valid & in_ready_q;
    assign emit   = m_q.vld & bus.out_ready;
    // An all-killed bundle still handshakes but never occupies an entry.
    assign store  = accept & in_e.vld;

    always_comb begin
        m_d     = m_q;
        s_d     = s_q;
        stall_d = stall_q;
        if (m_q.vld && !bus.out_ready && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
        if (bus.flush_all) begin
            m_d = '0;
            s_d = '0;
        end else if (!m_q.vld) begin
            if (store) m_d = in_e;
        end else if (emit) begin
            if (s_q.vld) begin
                m_d = s_q;
                s_d = '0;
            end else if (store) begin
                m_d = in_e;
            end else begin
                m_d = '0;
            end
        end else if (store) begin
            s_d = in_e;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m_q        <= '0;
            s_q        <= '0;
            in_ready_q <= 1'b1;
            stall_q    <= '0;
        end else begin
            m_q        <= m_d;
            s_q        <= s_d;
            in_ready_q <= ~s_d.vld;
            stall_q    <= stall_d;
        end
    end

    always_comb begin
        bus.out_ctrl = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (m_q.lv[i]) bus.out_ctrl[i*CTRL_W +: CTRL_W] = m_q.ct[i*CTRL_W +: CTRL_W];
        end
    end

    assign bus.in_ready       = in_ready_q;
    assign bus.out_valid      = m_q.vld;
    assign bus.out_lane_valid = m_q.lv;
    assign bus.out_payload    = m_q.pl;
    assign bus.occupancy      = {1'b0, m_q.vld} + {1'b0, s_q.vld};
    assign bus.stall_cnt      = stall_q;
endmodule

// File: tb/tb_ex_mem_stage_skid.sv
// Bench for ex_mem_stage_skid: two instances (KILL_YOUNGER=1/16-bit counter and
// KILL_YOUNGER=0/4-bit counter) driven identically and checked against a FIFO model.
module tb_ex_mem_stage_skid;
    localparam int unsigned LANES = 2;
    localparam int unsigned PWL   = 85;
    localparam int unsigned CWL   = 5;
    localparam int unsigned PW    = LANES * PWL;
    localparam int unsigned CW    = LANES * CWL;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ex_mem_stage_skid_if #(.LANES(LANES), .PAYLOAD_W(PWL), .CTRL_W(CWL), .STALL_CNT_W(16)) b0 ();
    ex_mem_stage_skid_if #(.LANES(LANES), .PAYLOAD_W(PWL), .CTRL_W(CWL), .STALL_CNT_W(4))  b1 ();

    ex_mem_stage_skid #(.LANES(LANES), .PAYLOAD_W(PWL), .CTRL_W(CWL), .KILL_YOUNGER(1), .STALL_CNT_W(16))
        u0 (.clk(clk), .reset(reset), .bus(b0.slave));
    ex_mem_stage_skid #(.LANES(LANES), .PAYLOAD_W(PWL), .CTRL_W(CWL), .KILL_YOUNGER(0), .STALL_CNT_W(4))
        u1 (.clk(clk), .reset(reset), .bus(b1.slave));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs as last applied (shared by both instances and the model)
    logic          g_rst, g_iv, g_fa, g_ordy;
    logic [1:0]    g_lv, g_fl;
    logic [PW-1:0] g_pl;
    logic [CW-1:0] g_ct;

    task automatic set_in(input logic rst, input logic iv, input logic [1:0] lv, input logic [1:0] fl,
                          input logic fa, input logic ordy, input logic [PW-1:0] pl, input logic [CW-1:0] ct);
        g_rst = rst; g_iv = iv; g_lv = lv; g_fl = fl; g_fa = fa; g_ordy = ordy; g_pl = pl; g_ct = ct;
        reset = rst;
        b0.in_valid = iv; b0.in_lane_valid = lv; b0.flush_lane = fl; b0.flush_all = fa;
        b0.out_ready = ordy; b0.in_payload = pl; b0.in_ctrl = ct;
        b1.in_valid = iv; b1.in_lane_valid = lv; b1.flush_lane = fl; b1.flush_all = fa;
        b1.out_ready = ordy; b1.in_payload = pl; b1.in_ctrl = ct;
    endtask

    // Reference: each instance is a depth-2 FIFO of bundles plus a saturating counter.
    typedef struct packed {
        logic [1:0]    lv;
        logic [PW-1:0] pl;
        logic [CW-1:0] ct;
    } bund_t;

    bund_t mq [2][2];
    int    msz [2];
    int    mst [2];
    int    smax [2] = '{65535, 15};
    int    ky [2]   = '{1, 0};

    task automatic model_step(input int k);
        bit rdy, ov, kl;
        bund_t b;
        if (g_rst) begin
            msz[k] = 0;
            mst[k] = 0;
            return;
        end
        rdy = (msz[k] < 2);
        ov  = (msz[k] > 0);
        if (ov && !g_ordy && mst[k] < smax[k]) mst[k]++;
        if (g_fa) begin
            msz[k] = 0;
            return;
        end
        if (ov && g_ordy) begin
            mq[k][0] = mq[k][1];
            msz[k]--;
        end
        if (g_iv && rdy) begin
            b = '0;
            for (int i = 0; i < 2; i++) begin
                kl = g_fl[i] || (ky[k] != 0 && (g_fl & 2'((1 << i) - 1)) != 0);
                b.lv[i] = g_lv[i] & ~kl;
                if (!kl) b.pl[i*PWL +: PWL] = g_pl[i*PWL +: PWL];
                if (b.lv[i]) b.ct[i*CWL +: CWL] = g_ct[i*CWL +: CWL];
            end
            if (b.lv != 0) begin
                mq[k][msz[k]] = b;
                msz[k]++;
            end
        end
    endtask

    task automatic cmp_dut(input int k, input logic ov, input logic [1:0] occ, input logic ir,
                           input logic [1:0] olv, input logic [PW-1:0] pl, input logic [CW-1:0] ct,
                           input logic [15:0] st);
        bund_t h;
        h = (msz[k] > 0) ? mq[k][0] : '0;
        chk($sformatf("d%0d_out_valid", k), 256'(ov), 256'(msz[k] > 0));
        chk($sformatf("d%0d_occupancy", k), 256'(occ), 256'(msz[k]));
        chk($sformatf("d%0d_in_ready", k), 256'(ir), 256'(msz[k] < 2));
        chk($sformatf("d%0d_out_lane_valid", k), 256'(olv), 256'(h.lv));
        chk($sformatf("d%0d_out_payload", k), 256'(pl), 256'(h.pl));
        chk($sformatf("d%0d_out_ctrl", k), 256'(ct), 256'(h.ct));
        chk($sformatf("d%0d_stall_cnt", k), 256'(st), 256'(mst[k]));
    endtask

    task automatic tick();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        cmp_dut(0, b0.out_valid, b0.occupancy, b0.in_ready, b0.out_lane_valid, b0.out_payload,
                b0.out_ctrl, b0.stall_cnt);
        cmp_dut(1, b1.out_valid, b1.occupancy, b1.in_ready, b1.out_lane_valid, b1.out_payload,
                b1.out_ctrl, 16'(b1.stall_cnt));
    endtask

    typedef struct {
        logic rst, iv; logic [1:0] lv, fl; logic fa, ordy; logic [7:0] tag;
        logic ov; logic [1:0] occ; logic ir; logic [1:0] olv; logic [7:0] p0; int st;
        logic [1:0] olv1; int st1;
    } vec_t;

    function automatic vec_t mk(logic rst, logic iv, logic [1:0] lv, logic [1:0] fl, logic fa, logic ordy,
                                logic [7:0] tag, logic ov, logic [1:0] occ, logic ir, logic [1:0] olv,
                                logic [7:0] p0, int st, logic [1:0] olv1, int st1);
        vec_t v;
        v.rst = rst; v.iv = iv; v.lv = lv; v.fl = fl; v.fa = fa; v.ordy = ordy; v.tag = tag;
        v.ov = ov; v.occ = occ; v.ir = ir; v.olv = olv; v.p0 = p0; v.st = st; v.olv1 = olv1; v.st1 = st1;
        return v;
    endfunction

    function automatic logic [PW-1:0] tag_pl(logic [7:0] tag);
        logic [PW-1:0] p;
        p = '0;
        p[7:0]     = 8'h10 + tag;
        p[PWL +: 8] = 8'h20 + tag;
        return p;
    endfunction

    vec_t tv [19];

    initial begin
        logic [191:0] rnd;
        //         rst iv lv     fl     fa ordy tag    ov occ   ir olv    p0     st  olv1  st1
        tv[0]  = mk(1, 0, 2'b11, 2'b00, 0, 1, 8'd0,  0, 2'd0, 1, 2'b00, 8'h00, 0, 2'b00, 0);
        tv[1]  = mk(0, 1, 2'b11, 2'b00, 0, 1, 8'd0,  1, 2'd1, 1, 2'b11, 8'h10, 0, 2'b11, 0);
        tv[2]  = mk(0, 1, 2'b11, 2'b00, 0, 1, 8'd1,  1, 2'd1, 1, 2'b11, 8'h11, 0, 2'b11, 0);
        tv[3]  = mk(0, 1, 2'b11, 2'b00, 0, 1, 8'd2,  1, 2'd1, 1, 2'b11, 8'h12, 0, 2'b11, 0);
        tv[4]  = mk(0, 1, 2'b11, 2'b00, 0, 1, 8'd3,  1, 2'd1, 1, 2'b11, 8'h13, 0, 2'b11, 0);
        tv[5]  = mk(0, 0, 2'b11, 2'b00, 0, 1, 8'd0,  0, 2'd0, 1, 2'b00, 8'h00, 0, 2'b00, 0);
        tv[6]  = mk(0, 1, 2'b11, 2'b00, 0, 0, 8'd4,  1, 2'd1, 1, 2'b11, 8'h14, 0, 2'b11, 0);
        tv[7]  = mk(0, 1, 2'b11, 2'b00, 0, 0, 8'd5,  1, 2'd2, 0, 2'b11, 8'h14, 1, 2'b11, 1);
        tv[8]  = mk(0, 1, 2'b11, 2'b00, 0, 0, 8'd6,  1, 2'd2, 0, 2'b11, 8'h14, 2, 2'b11, 2);
        tv[9]  = mk(0, 0, 2'b11, 2'b00, 0, 1, 8'd0,  1, 2'd1, 1, 2'b11, 8'h15, 2, 2'b11, 2);
        tv[10] = mk(0, 0, 2'b11, 2'b00, 0, 1, 8'd0,  0, 2'd0, 1, 2'b00, 8'h00, 2, 2'b00, 2);
        tv[11] = mk(0, 1, 2'b11, 2'b01, 0, 1, 8'd7,  0, 2'd0, 1, 2'b00, 8'h00, 2, 2'b10, 2);
        tv[12] = mk(0, 0, 2'b11, 2'b00, 0, 1, 8'd0,  0, 2'd0, 1, 2'b00, 8'h00, 2, 2'b00, 2);
        tv[13] = mk(0, 1, 2'b11, 2'b00, 0, 0, 8'd8,  1, 2'd1, 1, 2'b11, 8'h18, 2, 2'b11, 2);
        tv[14] = mk(0, 1, 2'b11, 2'b00, 0, 0, 8'd9,  1, 2'd2, 0, 2'b11, 8'h18, 3, 2'b11, 3);
        tv[15] = mk(0, 1, 2'b11, 2'b00, 1, 0, 8'd10, 0, 2'd0, 1, 2'b00, 8'h00, 4, 2'b00, 4);
        tv[16] = mk(0, 0, 2'b11, 2'b00, 0, 0, 8'd0,  0, 2'd0, 1, 2'b00, 8'h00, 4, 2'b00, 4);
        tv[17] = mk(0, 1, 2'b11, 2'b10, 0, 1, 8'd11, 1, 2'd1, 1, 2'b01, 8'h1B, 4, 2'b01, 4);
        tv[18] = mk(0, 1, 2'b00, 2'b00, 0, 1, 8'd12, 0, 2'd0, 1, 2'b00, 8'h00, 4, 2'b00, 4);

        msz = '{0, 0};
        mst = '{0, 0};
        set_in(1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, '0, '0);

        for (int i = 0; i < 19; i++) begin
            set_in(tv[i].rst, tv[i].iv, tv[i].lv, tv[i].fl, tv[i].fa, tv[i].ordy,
                   tag_pl(tv[i].tag), {5'h05, 5'h1A});
            tick();
            chk($sformatf("v%0d_ov", i), 256'(b0.out_valid), 256'(tv[i].ov));
            chk($sformatf("v%0d_occ", i), 256'(b0.occupancy), 256'(tv[i].occ));
            chk($sformatf("v%0d_ir", i), 256'(b0.in_ready), 256'(tv[i].ir));
            chk($sformatf("v%0d_olv", i), 256'(b0.out_lane_valid), 256'(tv[i].olv));
            chk($sformatf("v%0d_p0", i), 256'(b0.out_payload[7:0]), 256'(tv[i].p0));
            chk($sformatf("v%0d_st", i), 256'(b0.stall_cnt), 256'(tv[i].st));
            chk($sformatf("v%0d_olv1", i), 256'(b1.out_lane_valid), 256'(tv[i].olv1));
            chk($sformatf("v%0d_st1", i), 256'(b1.stall_cnt), 256'(tv[i].st1));
        end

        // Long stall: 16-bit counter keeps counting, 4-bit one pins at 15
        set_in(1'b0, 1'b1, 2'b11, 2'b00, 1'b0, 1'b0, tag_pl(8'd13), {5'h05, 5'h1A});
        tick();
        set_in(1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, tag_pl(8'd14), {5'h05, 5'h1A});
        for (int i = 0; i < 20; i++) tick();
        chk("sat_st0", 256'(b0.stall_cnt), 256'd24);
        chk("sat_st1", 256'(b1.stall_cnt), 256'd15);

        // Reset while stalled with a bundle held
        set_in(1'b1, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, '0, '0);
        tick();
        chk("rst_ov", 256'(b0.out_valid), 256'd0);
        chk("rst_ir", 256'(b0.in_ready), 256'd1);
        chk("rst_occ", 256'(b0.occupancy), 256'd0);
        chk("rst_pl", 256'(b0.out_payload), 256'd0);
        chk("rst_st0", 256'(b0.stall_cnt), 256'd0);
        chk("rst_st1", 256'(b1.stall_cnt), 256'd0);

        for (int n = 0; n < 1500; n++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            set_in($urandom_range(0, 99) == 0,
                   $urandom_range(0, 3) != 0,
                   2'($urandom),
                   ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00,
                   $urandom_range(0, 29) == 0,
                   $urandom_range(0, 9) < ((n / 300) % 2 == 0 ? 3 : 7),
                   rnd[PW-1:0],
                   CW'($urandom));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
